// File: rtl/mandel_pkg.sv
// Shared constants and types for the Mandelbrot pixel-coordinate generator.
// Fixed point is 4.23 two's complement, matching the HPS PIO word width.
package mandel_pkg;

    localparam int DEF_WIDTH    = 27;
    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_PIXELS = 480;
    localparam int FRAC_BITS    = 23;
    localparam int INT_BITS     = DEF_WIDTH - FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mandel_coord_gen_if.sv
// Valid/ready point stream from the coordinate generator to the iterator array.
// The master drives the point and valid; the slave drives ready.
interface mandel_coord_gen_if #(
    parameter int WIDTH = 27,
    parameter int X_W   = 10,
    parameter int Y_W   = 9
);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c_re;
    logic [WIDTH-1:0] c_im;
    logic [X_W-1:0]   pix_x;
    logic [Y_W-1:0]   pix_y;

    modport master (
        output out_valid,
        output c_re,
        output c_im,
        output pix_x,
        output pix_y,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  c_re,
        input  c_im,
        input  pix_x,
        input  pix_y,
        output out_ready
    );

endinterface

// File: rtl/mandel_step_acc.sv
// Load/step/hold accumulator; load wins over step, arithmetic wraps mod 2^WIDTH.
// SUB selects subtraction so the imaginary axis can walk downward on screen.
module mandel_step_acc #(
    parameter int WIDTH = 27,
    parameter bit SUB   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_delta,
    output logic [WIDTH-1:0] o_acc
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_next;

    assign w_next = SUB ? (r_acc - i_delta) : (r_acc + i_delta);
    assign o_acc  = r_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_load_val;
        end else if (i_step) begin
            r_acc <= w_next;
        end
    end

endmodule

// File: rtl/mandel_coord_gen.sv
// Raster-order complex-point generator: latches frame parameters on start,
// then emits one (c_re, c_im, pix_x, pix_y) per accepted valid/ready handshake.
module mandel_coord_gen
    import mandel_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_PIXELS = DEF_V_PIXELS,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WIDTH-1:0]  x_start,
    input  logic [WIDTH-1:0]  y_start,
    input  logic [WIDTH-1:0]  dx,
    input  logic [WIDTH-1:0]  dy,
    mandel_coord_gen_if.master out_if,
    output logic              busy,
    output logic              done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_x0;
    logic [WIDTH-1:0] r_y0;
    logic [WIDTH-1:0] r_dx;
    logic [WIDTH-1:0] r_dy;
    logic [X_W-1:0]   r_px;
    logic [Y_W-1:0]   r_py;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_start;
    logic             w_hs;
    logic             w_row_end;
    logic             w_last;
    logic             w_re_load;
    logic [WIDTH-1:0] w_re_val;
    logic             w_re_step;
    logic             w_im_step;
    logic [WIDTH-1:0] w_re;
    logic [WIDTH-1:0] w_im;

    // abort blocks both a fresh start and an in-flight handshake
    assign w_start   = (r_state == IDLE) && start && !abort;
    assign w_hs      = (r_state == RUN) && r_valid
                       && out_if.out_ready && !abort;
    assign w_row_end = (r_px == X_LAST);
    assign w_last    = w_row_end && (r_py == Y_LAST);

    assign w_re_load = w_start || (w_hs && w_row_end && !w_last);
    assign w_re_val  = w_start ? x_start : r_x0;
    assign w_re_step = w_hs && !w_row_end;
    assign w_im_step = w_hs && w_row_end && !w_last;

    mandel_step_acc #(
        .WIDTH (WIDTH),
        .SUB   (1'b0)
    ) u_re_acc (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_re_load),
        .i_load_val (w_re_val),
        .i_step     (w_re_step),
        .i_delta    (r_dx),
        .o_acc      (w_re)
    );

    mandel_step_acc #(
        .WIDTH (WIDTH),
        .SUB   (1'b1)
    ) u_im_acc (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_start),
        .i_load_val (y_start),
        .i_step     (w_im_step),
        .i_delta    (r_dy),
        .o_acc      (w_im)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_px    <= '0;
            r_py    <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_x0    <= x_start;
                        r_y0    <= y_start;
                        r_dx    <= dx;
                        r_dy    <= dy;
                        r_px    <= '0;
                        r_py    <= '0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_hs) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else if (w_row_end) begin
                            r_px <= '0;
                            r_py <= r_py + 1'b1;
                        end else begin
                            r_px <= r_px + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_if.out_valid = r_valid;
    assign out_if.c_re      = w_re;
    assign out_if.c_im      = w_im;
    assign out_if.pix_x     = r_px;
    assign out_if.pix_y     = r_py;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule
